// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read-port register file with byte-lane writes,
// optional same-cycle write forwarding and a per-register pending-write
// scoreboard used by ID to detect RAW hazards on outstanding writebacks.
//
// Ports
//   clk, reset        rising-edge clock, async active-low reset
//   wr_en/addr/data/be  write port, byte-lane enables
//   rd_addr/rd_data   NUM_RD packed read ports, port k at slice k
//   rd_busy           per-port "register has a pending write"
//   rsv_en/rsv_addr   reserve a register (mark pending)
//   flush             drop every reservation
//   busy_cnt          number of reserved registers
//   v0, a0, sp, ra    raw taps of entries 2, 4, 29, 31 (never forwarded)

// One read port: entry select, forwarding and busy masking.
module regfile_rd_port #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic [2**ADDR_W-1:0][DATA_W-1:0] mem,
  input  logic [2**ADDR_W-1:0]             busy,
  input  logic                             fwd_en,
  input  logic [ADDR_W-1:0]                wr_addr,
  input  logic [DATA_W-1:0]                wr_merged,
  input  logic [ADDR_W-1:0]                addr,
  output logic [DATA_W-1:0]                data,
  output logic                             busy_o
);
  logic zero, hit;

  assign zero = (addr == '0);
  // A forwarded write resolves the hazard in the same cycle.
  assign hit  = (BYPASS != 0) && fwd_en && (wr_addr == addr) && !zero;

  assign data   = zero ? '0 : (hit ? wr_merged : mem[addr]);
  assign busy_o = busy[addr] && !zero && !hit;
endmodule

module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt,
  output logic [DATA_W-1:0]        v0,
  output logic [DATA_W-1:0]        a0,
  output logic [DATA_W-1:0]        sp,
  output logic [DATA_W-1:0]        ra
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;
  localparam int CNT_W = ADDR_W+1;

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             busy, busy_nxt;
  logic [DATA_W-1:0]            wr_merged;
  logic                         fwd_en, set_inc, clr_dec;

  // Value the write target will hold after the edge.
  always_comb begin
    wr_merged = mem[wr_addr];
    for (int i = 0; i < NB; i++)
      if (wr_be[i]) wr_merged[8*i +: 8] = wr_data[8*i +: 8];
  end

  // Forwarding is suppressed while reset is held so every read is zero.
  assign fwd_en = wr_en && reset;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset)
    if (!reset)                        mem <= '0;
    else if (wr_en && wr_addr != '0)   mem[wr_addr] <= wr_merged;

  // Reservation is applied after the write clear so the younger reserve wins.
  always_comb begin
    busy_nxt = busy;
    if (flush) busy_nxt = '0;
    else begin
      if (wr_en)  busy_nxt[wr_addr]  = 1'b0;
      if (rsv_en) busy_nxt[rsv_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Count only real transitions; a reserve+write on the same entry is neutral
  // when already busy and a plain set when idle.
  assign set_inc = rsv_en && (rsv_addr != '0) && !busy[rsv_addr];
  assign clr_dec = wr_en && (wr_addr != '0) && busy[wr_addr] &&
                   !(rsv_en && rsv_addr == wr_addr);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      if (flush) busy_cnt <= '0;
      else       busy_cnt <= busy_cnt + CNT_W'(set_inc) - CNT_W'(clr_dec);
    end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_port (
      .mem       (mem),
      .busy      (busy),
      .fwd_en    (fwd_en),
      .wr_addr   (wr_addr),
      .wr_merged (wr_merged),
      .addr      (rd_addr[k*ADDR_W +: ADDR_W]),
      .data      (rd_data[k*DATA_W +: DATA_W]),
      .busy_o    (rd_busy[k])
    );
  end

  // Taps read storage directly; entries beyond the depth read as zero.
  assign v0 = (DEPTH > 2)  ? mem[2  % DEPTH] : '0;
  assign a0 = (DEPTH > 4)  ? mem[4  % DEPTH] : '0;
  assign sp = (DEPTH > 29) ? mem[29 % DEPTH] : '0;
  assign ra = (DEPTH > 31) ? mem[31 % DEPTH] : '0;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed + random bench for regfile_scoreboard; drives one BYPASS=1 and one
// BYPASS=0 instance from the same stimulus.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, rsv_en, flush;
  logic [4:0]  wr_addr, rsv_addr, ra0, ra1;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [9:0]  rd_addr;
  logic [63:0] rdd_b, rdd_n;
  logic [1:0]  rb_b, rb_n;
  logic [5:0]  cnt_b, cnt_n;
  logic [31:0] v0_b, a0_b, sp_b, ra_b, v0_n, a0_n, sp_n, ra_n;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;
  assign rd_addr = {ra1, ra0};

  regfile_scoreboard #(.BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_addr(rd_addr), .rd_data(rdd_b), .rd_busy(rb_b),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(cnt_b),
    .v0(v0_b), .a0(a0_b), .sp(sp_b), .ra(ra_b));

  regfile_scoreboard #(.BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_addr(rd_addr), .rd_data(rdd_n), .rd_busy(rb_n),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .busy_cnt(cnt_n),
    .v0(v0_n), .a0(a0_n), .sp(sp_n), .ra(ra_n));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; return at the following negedge with inputs stable.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
  endtask

  task automatic rsv(input logic [4:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  // Reference model for the random phase.
  logic [31:0] mem_m [32];
  logic [31:0] busy_m;

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                      input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && wr_en && wr_addr == a) return mrg(mem_m[a], wr_data, wr_be);
    return mem_m[a];
  endfunction

  function automatic logic exp_bz(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && wr_en && wr_addr == a) return 1'b0;
    return busy_m[a];
  endfunction

  initial begin
    reset = 1'b0; idle(); wr_addr = 0; wr_data = 0; wr_be = 0; rsv_addr = 0;
    ra0 = 0; ra1 = 0;
    @(negedge clk);

    // Reset holds everything at zero, even a forwarded write.
    wr(5, 32'hDEADBEEF, 4'hF); ra0 = 5; #1;
    chk("rst_rd_byp", rdd_b[31:0], 32'h0);
    chk("rst_cnt", {cnt_b, cnt_n}, 12'h0);
    cyc(); #1;
    chk("rst_hold_rd", {rdd_b[31:0], rdd_n[31:0]}, 64'h0);
    @(negedge clk);
    reset = 1'b1; #1;
    chk("r5_byp_same", rdd_b[31:0], 32'hDEADBEEF);
    chk("r5_nob_old", rdd_n[31:0], 32'h0);
    cyc(); idle(); #1;
    chk("r5_after", {rdd_b[31:0], rdd_n[31:0]}, {2{32'hDEADBEEF}});

    // Byte lanes.
    @(negedge clk); wr(3, 32'h11223344, 4'hF); cyc();
    wr(3, 32'hAABBCCDD, 4'b0101); cyc(); idle(); ra0 = 3; #1;
    chk("lanes_r3", {rdd_b[31:0], rdd_n[31:0]}, {2{32'h11BB33DD}});

    // Entry 0 ignores writes and reservations.
    @(negedge clk); wr(0, 32'hFFFFFFFF, 4'hF); rsv(0); ra1 = 0; cyc(); idle(); #1;
    chk("r0_rd", {rdd_b[63:32], rdd_n[63:32]}, 64'h0);
    chk("r0_cnt", {cnt_b, cnt_n}, 12'h0);
    chk("r0_busy", {rb_b[1], rb_n[1]}, 2'b00);

    // Bypass merges the low lane into the old value.
    @(negedge clk); wr(7, 32'h12345600, 4'hF); cyc();
    wr(7, 32'hAAAAAA77, 4'h1); ra0 = 7; #1;
    chk("byp_merge", rdd_b[31:0], 32'h12345677);
    chk("nob_old", rdd_n[31:0], 32'h12345600);
    cyc(); idle(); #1;
    chk("nob_new", rdd_n[31:0], 32'h12345677);

    // Scoreboard basics.
    @(negedge clk); rsv(8); cyc(); rsv(9); cyc(); idle(); ra0 = 8; ra1 = 9; #1;
    chk("sb_cnt2", {cnt_b, cnt_n}, {2{6'd2}});
    chk("sb_busy89", {rb_b, rb_n}, 4'b1111);
    @(negedge clk); wr(8, 32'h8, 4'hF); #1;
    chk("sb_wr8_fwd", {rb_b, rb_n}, 4'b1011);
    cyc(); idle(); #1;
    chk("sb_cnt1", {cnt_b, cnt_n}, {2{6'd1}});
    chk("sb_busy9", {rb_b, rb_n}, 4'b1010);
    @(negedge clk); rsv(9); cyc(); idle(); #1;
    chk("sb_rersv9", {cnt_b, cnt_n}, {2{6'd1}});

    // Simultaneous reserve and write on busy r10.
    @(negedge clk); rsv(10); cyc(); idle(); #1;
    chk("sim_cnt2", cnt_b, 6'd2);
    @(negedge clk); rsv(10); wr(10, 32'hA, 4'hF); cyc(); idle(); ra0 = 10; #1;
    chk("sim_r10_cnt", {cnt_b, cnt_n}, {2{6'd2}});
    chk("sim_r10_busy", {rb_b[0], rb_n[0]}, 2'b11);
    chk("sim_r10_data", rdd_b[31:0], 32'hA);

    // Reserve r11 while clearing busy r12: net zero.
    @(negedge clk); rsv(12); cyc(); idle(); #1;
    chk("sim_cnt3", cnt_b, 6'd3);
    @(negedge clk); rsv(11); wr(12, 32'hC, 4'hF); cyc(); idle(); ra0 = 11; ra1 = 12; #1;
    chk("sim_net0", {cnt_b, cnt_n}, {2{6'd3}});
    chk("sim_busy1112", {rb_b, rb_n}, 4'b0101);

    // Flush beats a same-cycle reservation; the write still lands.
    @(negedge clk); flush = 1'b1; rsv(13); wr(14, 32'h14, 4'hF); cyc(); idle();
    ra0 = 13; ra1 = 14; #1;
    chk("flush_cnt", {cnt_b, cnt_n}, 12'h0);
    chk("flush_busy", {rb_b, rb_n}, 4'b0000);
    chk("flush_wr", rdd_n[63:32], 32'h14);

    // Taps are never forwarded.
    @(negedge clk); wr(31, 32'h31313131, 4'hF); cyc(); wr(2, 32'h02020202, 4'hF); #1;
    chk("tap_nobyp", {v0_b, a0_b, sp_b, ra_b}, {32'h0, 32'h0, 32'h0, 32'h31313131});
    cyc(); idle(); #1;
    chk("tap_v0", v0_b, 32'h02020202);

    // Reset mid-operation discards state and in-flight work.
    @(negedge clk); rsv(20); cyc(); idle(); #1;
    chk("mid_cnt1", cnt_b, 6'd1);
    @(negedge clk); reset = 1'b0; wr(5, 32'h55, 4'hF); rsv(21); ra0 = 5; #1;
    chk("mid_rst_cnt", {cnt_b, cnt_n}, 12'h0);
    chk("mid_rst_rd", {rdd_b[31:0], rdd_n[31:0]}, 64'h0);
    chk("mid_rst_tap", {v0_b, ra_b}, 64'h0);
    cyc(); reset = 1'b1; idle(); #1;
    chk("mid_rel_cnt", {cnt_b, cnt_n}, 12'h0);
    chk("mid_rel_rd", rdd_n[31:0], 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 32; i++) mem_m[i] = 32'h0;
    busy_m = 32'h0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      wr_en = 1'($urandom_range(0, 1)); wr_addr = raddr(); wr_data = $urandom;
      wr_be = 4'($urandom_range(0, 15));
      rsv_en = ($urandom_range(0, 2) == 0); rsv_addr = raddr();
      flush = ($urandom_range(0, 19) == 0);
      ra0 = raddr(); ra1 = raddr();
      #1;
      chk("rnd_rd_byp", rdd_b, {exp_rd(ra1, 1'b1), exp_rd(ra0, 1'b1)});
      chk("rnd_rd_nob", rdd_n, {exp_rd(ra1, 1'b0), exp_rd(ra0, 1'b0)});
      chk("rnd_bz_byp", rb_b, {exp_bz(ra1, 1'b1), exp_bz(ra0, 1'b1)});
      chk("rnd_bz_nob", rb_n, {exp_bz(ra1, 1'b0), exp_bz(ra0, 1'b0)});
      chk("rnd_cnt", {cnt_b, cnt_n}, {2{6'($countones(busy_m))}});
      chk("rnd_taps", {v0_b, a0_b, sp_b, ra_b, v0_n, a0_n, sp_n, ra_n},
          {2{mem_m[2], mem_m[4], mem_m[29], mem_m[31]}});
      if (wr_en && wr_addr != 0) mem_m[wr_addr] = mrg(mem_m[wr_addr], wr_data, wr_be);
      if (flush) busy_m = 32'h0;
      else begin
        if (wr_en)  busy_m[wr_addr]  = 1'b0;
        if (rsv_en) busy_m[rsv_addr] = 1'b1;
      end
      busy_m[0] = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-read-port register file with byte-lane writes, optional same-cycle write bypass and a per-register pending-write scoreboard. It replaces the fixed 32x32 two-read register file in the multi-cycle and pipelined MIPS cores. The ID stage uses it to read operands and detect RAW hazards on registers whose writeback is still outstanding. Entry 0 is hardwired to zero. Four fixed debug taps feed the board display logic.

## Interface
- DATA_W, 32: register width in bits; must be a multiple of 8.
- ADDR_W, 5: address width; depth is 2^ADDR_W entries.
- NUM_RD, 2: number of read ports, 1..4.
- BYPASS, 1: 1 forwards a same-cycle write to the read ports; 0 disables forwarding.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte-lane enables; bit i covers bits [8i+7:8i].
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k uses slice [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data, packed the same way.
- rd_busy  out  NUM_RD  port k's register has an unresolved pending write.
- rsv_en  in  1  reserve rsv_addr, marking it pending.
- rsv_addr  in  ADDR_W  register to reserve.
- flush  in  1  clear all reservations.
- busy_cnt  out  ADDR_W+1  number of currently reserved registers.
- v0, a0, sp, ra  out  DATA_W each  taps of entries 2, 4, 29 and 31.

## Operation
- **Storage:** entries 1..2^ADDR_W-1 are flops.
  - Entry 0 always reads 0.
  - Writes and reservations to address 0 are ignored and never affect busy_cnt.
- **Write:** on a rising clk with wr_en=1, each lane with wr_be[i]=1 takes wr_data; other lanes hold their value.
  - wr_be=0 with wr_en=1 leaves data unchanged but still clears the reservation.
- **Read:** combinational. rd_data_k = entry[rd_addr_k].
  - If BYPASS=1, wr_en=1 and wr_addr==rd_addr_k!=0, then rd_data_k is the lane-merged value, i.e. the value the entry will hold after the edge.
  - Taps (v0, a0, sp, ra) are never bypassed.
- **Scoreboard:** one busy bit per entry, updated on a rising clk in this priority order:
  1. flush=1: all busy bits clear, busy_cnt becomes 0, and rsv_en is ignored that cycle. A write in the same cycle still updates data.
  2. rsv_en=1 and wr_en=1 with rsv_addr==wr_addr: the bit ends set, because the younger reservation wins.
  3. Otherwise: rsv_en sets busy[rsv_addr] and wr_en clears busy[wr_addr], independently.
- **busy_cnt:** registered and updated incrementally.
  - +1 only when a bit goes 0→1.
  - −1 only when a bit goes 1→0.
  - Net 0 when one bit sets and a different bit clears in the same cycle.
  - Must always equal the popcount of the busy bits.
- **rd_busy_k:** busy[rd_addr_k], forced to 0 in two cases:
  - rd_addr_k==0.
  - BYPASS=1 and a same-cycle write to rd_addr_k is being forwarded.

## Timing
- Reads, rd_busy and taps: zero latency, combinational from addresses and state.
- A write is visible through a non-bypassed path one cycle after the write edge.
- A reservation is visible on rd_busy the cycle after rsv_en.
- busy_cnt reflects an edge's updates immediately after that edge.
- **Reset (reset=0):** immediately and asynchronously:
  - all entries and taps read 0;
  - all busy bits clear, so rd_busy=0 and busy_cnt=0.
- **Reset mid-operation:** discards any in-flight write or reservation. Deassertion is synchronous to the design; the first edge after deassertion behaves normally.

## Test plan
- **Reset:** hold reset=0, write 0xDEADBEEF to r5 → r5 reads 0 and busy_cnt=0. Release reset, repeat the write → r5 reads 0xDEADBEEF next cycle.
- **Byte lanes:** write r3=0x11223344 with be=4'hF, then 0xAABBCCDD with be=4'b0101 → r3=0x11BB33DD. A write of 0xFFFFFFFF to r0 → r0 reads 0 and busy_cnt is unchanged.
- **Bypass:** with BYPASS=1, write 0x00000077 to r7 with be=4'h1 while rd_addr0=7 → rd_data0 shows the merged value in the same cycle. With BYPASS=0 → old value this cycle, new value next cycle.
- **Scoreboard:**
  - reserve r8, r9 → busy_cnt=2 and rd_busy set on ports addressing them;
  - write r8 → busy_cnt=1;
  - reserve r9 again → busy_cnt stays 1.
- **Simultaneous events:**
  - rsv_en and wr_en both on r10 while r10 is busy → busy stays set and busy_cnt is unchanged;
  - rsv_en on r11 with wr_en on busy r12 → busy_cnt net 0;
  - flush together with rsv_en on r13 → busy_cnt=0 and r13 not busy.
- **Random:** 10k cycles of random wr/rsv/flush traffic against a reference model → rd_data, rd_busy and taps match every cycle, and busy_cnt equals the popcount of the busy bits.
